perceptron_train_ctrl: RTL and testbench

//  Sequencer for perceptron training: holds a small sample/label store and the weight registers.

---
 rtl/perceptron_train_ctrl.sv | 249 ++++++++++++++++++++++++
 tb/tb_perceptron_train_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/perceptron_train_ctrl.sv
// Perceptron training sequencer: sample/label store, weight registers, one shared MAC stepped per dimension.
// Latency: N_DIM+2 cycles per correctly classified sample, 2*N_DIM+2 when misclassified; done 1 cycle after the last NXT.
// Backpressure: none; start is ignored while busy, and x/lbl/w writes are ignored while busy.
//
// Optional feature macro: PERCEPTRON_BIAS_EN adds a bias weight at index N_DIM driven by a constant input of 1.
//
// Ports:
//   clk, rst             clock (rising edge), synchronous active-high reset
//   start                pulse to begin a training run (only honoured in IDLE)
//   x_we/x_ws/x_wd/x_wdata   feature store write port [sample][dimension]
//   lbl_we/lbl_wdata     label write for sample x_ws
//   w_we/w_idx/w_wdata   weight write; w_idx also selects the combinational w_rdata readback
//   busy, done           run in progress, one-cycle end-of-run pulse
//   converged, epoch_cnt, err_cnt, pred   run status, held until the next start
module perceptron_train_ctrl #(
    parameter int N_SAMPLES  = 3,
    parameter int N_DIM      = 2,
    parameter int X_W        = 4,
    parameter int W_W        = 8,
    parameter int ACC_W      = 16,
    parameter int MAX_EPOCHS = 15,
    parameter int LR_SHIFT   = 0,
    localparam int S_W       = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1,
    localparam int D_W       = (N_DIM > 1) ? $clog2(N_DIM) : 1,
    localparam int WI_W      = $clog2(N_DIM + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            x_we,
    input  logic [S_W-1:0]  x_ws,
    input  logic [D_W-1:0]  x_wd,
    input  logic [X_W-1:0]  x_wdata,
    input  logic            lbl_we,
    input  logic            lbl_wdata,
    input  logic            w_we,
    input  logic [WI_W-1:0] w_idx,
    input  logic [W_W-1:0]  w_wdata,
    output logic [W_W-1:0]  w_rdata,
    output logic            busy,
    output logic            done,
    output logic            converged,
    output logic [3:0]      epoch_cnt,
    output logic [7:0]      err_cnt,
    output logic            pred
);

`ifdef PERCEPTRON_BIAS_EN
    localparam int N_W = N_DIM + 1;
`else
    localparam int N_W = N_DIM;
`endif
    localparam int DC_W   = (N_W > 1) ? $clog2(N_W) : 1;
    localparam int PROD_W = X_W + W_W + 1;
    localparam int SUM_W  = W_W + X_W + 2;

    localparam logic signed [W_W-1:0]   W_MAX_V = {1'b0, {(W_W-1){1'b1}}};
    localparam logic signed [W_W-1:0]   W_MIN_V = {1'b1, {(W_W-1){1'b0}}};
    localparam logic signed [SUM_W-1:0] SUM_MAX = SUM_W'(W_MAX_V);
    localparam logic signed [SUM_W-1:0] SUM_MIN = SUM_W'(W_MIN_V);

    typedef enum logic [2:0] {IDLE, MAC, ACT, UPD, NXT, DONE} state_t;

    state_t                  state;
    logic [S_W-1:0]          s;
    logic [DC_W-1:0]         d;
    logic signed [ACC_W-1:0] acc;
    logic                    epoch_err;
    logic                    err_neg;     // sign of the pending update: 1 means err = -1

    logic [X_W-1:0]          x_mem   [N_SAMPLES][N_DIM];
    logic                    lbl_mem [N_SAMPLES];
    logic signed [W_W-1:0]   w_reg   [N_W];

    logic [X_W-1:0]           x_cur;
    logic                     is_bias;
    logic signed [W_W-1:0]    w_cur;
    logic signed [PROD_W-1:0] prod;
    logic                     act_pred;
    logic [3:0]               epoch_nxt;
    logic [X_W-1:0]           delta;
    logic signed [SUM_W-1:0]  w_ext;
    logic signed [SUM_W-1:0]  dx_ext;
    logic signed [SUM_W-1:0]  upd_sum;
    logic signed [W_W-1:0]    w_upd;

    // Operand for the current dimension; the bias slot (if present) sees a constant 1.
    always_comb begin
        x_cur   = X_W'(1);
        is_bias = 1'b1;
        if (32'(d) < N_DIM) begin
            x_cur   = x_mem[s][D_W'(d)];
            is_bias = 1'b0;
        end
    end

    assign w_cur     = w_reg[d];
    assign prod      = PROD_W'($signed({1'b0, x_cur})) * PROD_W'(w_cur);
    assign act_pred  = !acc[ACC_W-1] && (acc != '0);   // strictly positive; zero predicts 0
    assign epoch_nxt = epoch_cnt + 4'd1;

    // Weight update with saturation; the sum is computed wide enough that it cannot wrap.
    always_comb begin
        delta   = is_bias ? X_W'(1) : (x_cur >> LR_SHIFT);
        w_ext   = SUM_W'(w_cur);
        dx_ext  = $signed(SUM_W'(delta));
        upd_sum = err_neg ? (w_ext - dx_ext) : (w_ext + dx_ext);
        if (upd_sum > SUM_MAX) begin
            w_upd = W_MAX_V;
        end else if (upd_sum < SUM_MIN) begin
            w_upd = W_MIN_V;
        end else begin
            w_upd = upd_sum[W_W-1:0];
        end
    end

    // Indices with no backing weight (e.g. the bias slot when disabled) read as 0.
    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < N_W; i++) begin
            if (32'(w_idx) == i) begin
                w_rdata = w_reg[i];
            end
        end
    end

    // Sample and label store: deliberately not reset so contents survive a run abort.
    always_ff @(posedge clk) begin
        if (!busy) begin
            if (x_we && (32'(x_ws) < N_SAMPLES) && (32'(x_wd) < N_DIM)) begin
                x_mem[x_ws][x_wd] <= x_wdata;
            end
            if (lbl_we && (32'(x_ws) < N_SAMPLES)) begin
                lbl_mem[x_ws] <= lbl_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            s         <= '0;
            d         <= '0;
            acc       <= '0;
            epoch_err <= 1'b0;
            err_neg   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            converged <= 1'b0;
            epoch_cnt <= '0;
            err_cnt   <= '0;
            pred      <= 1'b0;
            for (int i = 0; i < N_W; i++) begin
                w_reg[i] <= '0;
            end
        end else begin
            done <= 1'b0;

            // Host weight writes; a write in the start cycle lands before the first MAC cycle.
            if (!busy && w_we) begin
                for (int i = 0; i < N_W; i++) begin
                    if (32'(w_idx) == i) begin
                        w_reg[i] <= w_wdata;
                    end
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        s         <= '0;
                        d         <= '0;
                        acc       <= '0;
                        epoch_cnt <= '0;
                        err_cnt   <= '0;
                        epoch_err <= 1'b0;
                        converged <= 1'b0;
                        busy      <= 1'b1;
                        state     <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc + ACC_W'(prod);
                    if (32'(d) == N_W - 1) begin
                        d     <= '0;
                        state <= ACT;
                    end else begin
                        d <= d + 1'b1;
                    end
                end
                ACT: begin
                    pred <= act_pred;
                    if (lbl_mem[s] != act_pred) begin
                        // label 0 / pred 1 gives err = -1; label 1 / pred 0 gives +1
                        err_neg   <= act_pred;
                        epoch_err <= 1'b1;
                        d         <= '0;
                        if (err_cnt != 8'hFF) begin
                            err_cnt <= err_cnt + 8'd1;
                        end
                        state <= UPD;
                    end else begin
                        state <= NXT;
                    end
                end
                UPD: begin
                    w_reg[d] <= w_upd;
                    if (32'(d) == N_W - 1) begin
                        d     <= '0;
                        state <= NXT;
                    end else begin
                        d <= d + 1'b1;
                    end
                end
                NXT: begin
                    acc <= '0;
                    d   <= '0;
                    if (32'(s) < N_SAMPLES - 1) begin
                        s     <= s + 1'b1;
                        state <= MAC;
                    end else begin
                        epoch_cnt <= epoch_nxt;
                        if (!epoch_err) begin
                            converged <= 1'b1;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            state     <= DONE;
                        end else if (32'(epoch_nxt) >= MAX_EPOCHS) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= DONE;
                        end else begin
                            s         <= '0;
                            epoch_err <= 1'b0;
                            state     <= MAC;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_perceptron_train_ctrl.sv
// Bench for perceptron_train_ctrl: two instances share all inputs, one with MAX_EPOCHS=15, one with MAX_EPOCHS=1.
// Expected end-of-run status and weights are queued at start; a monitor pops and compares on each done pulse.
module tb_perceptron_train_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, x_we, lbl_we, lbl_wdata, w_we;
    logic [1:0] x_ws;
    logic [0:0] x_wd;
    logic [3:0] x_wdata;
    logic [1:0] stim_idx;
    logic [7:0] w_wdata;

    logic       own_a = 1'b0, own_b = 1'b0;
    logic [1:0] mon_idx_a = 2'd0, mon_idx_b = 2'd0;
    logic [1:0] w_idx_a, w_idx_b;
    logic [7:0] w_rdata_a, w_rdata_b, err_a, err_b;
    logic       busy_a, done_a, conv_a, pred_a;
    logic       busy_b, done_b, conv_b, pred_b;
    logic [3:0] epoch_a, epoch_b;

    assign w_idx_a = own_a ? mon_idx_a : stim_idx;
    assign w_idx_b = own_b ? mon_idx_b : stim_idx;

    perceptron_train_ctrl #(.MAX_EPOCHS(15)) u_dut_a (
        .clk(clk), .rst(rst), .start(start),
        .x_we(x_we), .x_ws(x_ws), .x_wd(x_wd), .x_wdata(x_wdata),
        .lbl_we(lbl_we), .lbl_wdata(lbl_wdata),
        .w_we(w_we), .w_idx(w_idx_a), .w_wdata(w_wdata), .w_rdata(w_rdata_a),
        .busy(busy_a), .done(done_a), .converged(conv_a),
        .epoch_cnt(epoch_a), .err_cnt(err_a), .pred(pred_a)
    );

    perceptron_train_ctrl #(.MAX_EPOCHS(1)) u_dut_b (
        .clk(clk), .rst(rst), .start(start),
        .x_we(x_we), .x_ws(x_ws), .x_wd(x_wd), .x_wdata(x_wdata),
        .lbl_we(lbl_we), .lbl_wdata(lbl_wdata),
        .w_we(w_we), .w_idx(w_idx_b), .w_wdata(w_wdata), .w_rdata(w_rdata_b),
        .busy(busy_b), .done(done_b), .converged(conv_b),
        .epoch_cnt(epoch_b), .err_cnt(err_b), .pred(pred_b)
    );

    typedef struct {
        int lat;    // rising edges from the start-sampling edge to done, inclusive
        int conv;
        int epoch;
        int errs;
        int pred;
        int w0;
        int w1;
        int st;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errs = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_errs++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
        end
    endtask

    function automatic exp_t mk(input int lat, input int conv, input int epoch, input int errs,
                                input int pred, input int w0, input int w1);
        exp_t e;
        e.lat = lat; e.conv = conv; e.epoch = epoch; e.errs = errs;
        e.pred = pred; e.w0 = w0; e.w1 = w1; e.st = 0;
        return e;
    endfunction

    // Monitor: compares status on the done cycle, then reads back weights 0..2 (index 2 must read 0).
    task automatic mon(input bit b);
        exp_t  e;
        string p;
        int    wv;
        p = b ? "dut_b" : "dut_a";
        if ((b ? q_b.size() : q_a.size()) == 0) begin
            n_checks++;
            n_errs++;
            $display("FAIL %s unexpected_done: got done=1, expected no done", p);
            return;
        end
        if (b) e = q_b.pop_front();
        else   e = q_a.pop_front();
        chk({p, " latency"},   cyc - e.st + 1, e.lat);
        chk({p, " converged"}, int'(b ? conv_b : conv_a), e.conv);
        chk({p, " epoch_cnt"}, int'(b ? epoch_b : epoch_a), e.epoch);
        chk({p, " err_cnt"},   int'(b ? err_b : err_a), e.errs);
        chk({p, " pred"},      int'(b ? pred_b : pred_a), e.pred);
        chk({p, " busy_at_done"}, int'(b ? busy_b : busy_a), 0);
        for (int i = 0; i < 3; i++) begin
            if (b) begin own_b = 1'b1; mon_idx_b = 2'(i); end
            else   begin own_a = 1'b1; mon_idx_a = 2'(i); end
            #1;
            wv = b ? int'($signed(w_rdata_b)) : int'($signed(w_rdata_a));
            chk($sformatf("%s w%0d", p, i), wv, (i == 0) ? e.w0 : ((i == 1) ? e.w1 : 0));
        end
        own_a = 1'b0;
        own_b = 1'b0;
    endtask

    always @(negedge clk) begin
        if (done_a) mon(1'b0);
        if (done_b) mon(1'b1);
    end

    task automatic load(input int xv[6], input int lb[3], input int w0, input int w1, input int w2);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            x_we = 1'b1; x_ws = 2'(i / 2); x_wd = 1'(i % 2); x_wdata = 4'(xv[i]);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            x_we = 1'b0; lbl_we = 1'b1; x_ws = 2'(i); lbl_wdata = 1'(lb[i]);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            lbl_we = 1'b0; w_we = 1'b1; stim_idx = 2'(i);
            w_wdata = 8'((i == 0) ? w0 : ((i == 1) ? w1 : w2));
        end
        @(negedge clk);
        w_we = 1'b0;
    endtask

    // disturb: re-pulse start and attempt label/weight writes while the run is busy.
    task automatic run(input exp_t ea, input exp_t eb, input bit disturb);
        bit fin;
        fin = 1'b0;
        @(negedge clk);
        start = 1'b1;
        ea.st = cyc + 1;
        eb.st = cyc + 1;
        q_a.push_back(ea);
        q_b.push_back(eb);
        for (int k = 0; k < 1000 && !fin; k++) begin
            @(negedge clk);
            start = 1'b0; lbl_we = 1'b0; w_we = 1'b0;
            if (disturb && k == 4) start = 1'b1;
            if (disturb && k == 5) begin
                lbl_we = 1'b1; x_ws = 2'd2; lbl_wdata = 1'b0;
                w_we = 1'b1; stim_idx = 2'd0; w_wdata = 8'd99;
            end
            if (k > 0 && !busy_a && !busy_b && q_a.size() == 0 && q_b.size() == 0) fin = 1'b1;
        end
        chk("run_completes", int'(fin), 1);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; x_we = 1'b0; lbl_we = 1'b0; lbl_wdata = 1'b0; w_we = 1'b0;
        x_ws = '0; x_wd = '0; x_wdata = '0; stim_idx = '0; w_wdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("reset busy_a", int'(busy_a), 0);
        chk("reset busy_b", int'(busy_b), 0);
        chk("reset done_a", int'(done_a), 0);
        chk("reset converged", int'(conv_a), 0);
        chk("reset epoch_cnt", int'(epoch_a), 0);
        chk("reset err_cnt", int'(err_a), 0);
        chk("reset pred", int'(pred_a), 0);
        stim_idx = 2'd0; #1;
        chk("reset w0", int'($signed(w_rdata_a)), 0);
        stim_idx = 2'd1; #1;
        chk("reset w1", int'($signed(w_rdata_a)), 0);

        // Separable set, already correct: one clean epoch; restart and busy writes must be ignored
        load('{2, 3, 4, 5, 1, 2}, '{1, 1, 1}, 4, 9, 0);
        run(mk(13, 1, 1, 0, 1, 4, 9), mk(13, 1, 1, 0, 1, 4, 9), 1'b1);

        // Not separable: 15 epochs on dut_a, single epoch on dut_b
        load('{2, 3, 4, 5, 1, 2}, '{0, 1, 1}, 4, 9, 0);
        run(mk(227, 0, 15, 23, 0, 3, 1), mk(15, 0, 1, 1, 1, 2, 6), 1'b0);

        // Saturation: w0 clamps at 127; write to the non-existent bias slot is dropped
        load('{15, 15, 15, 15, 15, 15}, '{1, 1, 1}, 125, -128, 55);
        run(mk(27, 1, 2, 1, 1, 127, -113), mk(15, 0, 1, 1, 1, 127, -113), 1'b0);

        // Reset in the middle of the first update of sample 0
        load('{2, 3, 4, 5, 1, 2}, '{0, 1, 1}, 4, 9, 0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        stim_idx = 2'd0; #1;
        chk("mid_upd err_cnt", int'(err_a), 1);
        chk("mid_upd w0", int'($signed(w_rdata_a)), 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort busy_a", int'(busy_a), 0);
        chk("abort busy_b", int'(busy_b), 0);
        chk("abort err_cnt", int'(err_a), 0);
        chk("abort epoch_cnt", int'(epoch_a), 0);
        chk("abort done", int'(done_a), 0);
        stim_idx = 2'd0; #1;
        chk("abort w0", int'($signed(w_rdata_a)), 0);
        stim_idx = 2'd1; #1;
        chk("abort w1", int'($signed(w_rdata_a)), 0);
        repeat (30) @(negedge clk);
        chk("abort stays idle", int'(busy_a), 0);
        chk("pending expectations", q_a.size() + q_b.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
